// File: rtl/alu_sched_pkg.sv
// Shared constants and types for the ALU round-robin scheduler.
package alu_sched_pkg;

  localparam int OPW = 2;
  localparam int DW  = 4;
  localparam int RW  = 5;

  localparam logic [OPW-1:0] OP_ADD   = 2'b00;
  localparam logic [OPW-1:0] OP_SUB   = 2'b01;
  localparam logic [OPW-1:0] OP_NOT_A = 2'b10;
  localparam logic [OPW-1:0] OP_ORB   = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches last_grant+1, +2, ... (mod N_REQ)
// and returns the first requester found as one-hot and as an index.
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int GNT_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GNT_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [GNT_W-1:0] grant_idx,
  output logic             grant_vld
);

  always_comb begin
    int cand;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = int'(last_grant) + off;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!grant_vld && req[cand]) begin
        grant_vld   = 1'b1;
        grant_idx   = GNT_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one registered ALU among N_REQ requesters with round-robin arbitration.
// One op in flight: IDLE accepts, ISSUE drives the ALU, CAPTURE samples C, RESP holds until taken.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int GNT_W = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [OPW*N_REQ-1:0] req_opcode,
  input  logic [DW*N_REQ-1:0]  req_a,
  input  logic [DW*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     resp_valid,
  input  logic [N_REQ-1:0]     resp_ready,
  output logic [RW-1:0]        resp_data,
  output logic [OPW-1:0]       alu_opcode,
  output logic [DW-1:0]        alu_a,
  output logic [DW-1:0]        alu_b,
  input  logic [RW-1:0]        alu_c,
  output logic                 busy
);

  state_t             state_q, state_d;
  logic [GNT_W-1:0]   last_grant_q;
  logic [GNT_W-1:0]   gnt_q;
  logic [N_REQ-1:0]   arb_grant;
  logic [GNT_W-1:0]   arb_idx;
  logic               arb_vld;
  logic               accept;
  logic               resp_done;
  logic [OPW-1:0]     sel_opcode;
  logic [DW-1:0]      sel_a;
  logic [DW-1:0]      sel_b;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_vld  (arb_vld)
  );

  assign accept    = (state_q == IDLE) && arb_vld;
  assign resp_done = (state_q == RESP) && resp_ready[gnt_q];

  always_comb begin
    sel_opcode = '0;
    sel_a      = '0;
    sel_b      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == GNT_W'(i)) begin
        sel_opcode = req_opcode[OPW*i +: OPW];
        sel_a      = req_a[DW*i +: DW];
        sel_b      = req_b[DW*i +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = ISSUE;
      ISSUE:                  state_d = CAPTURE;
      CAPTURE:                state_d = RESP;
      RESP:    if (resp_done) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // req_ready is gated by reset_n so nothing looks accepted while reset is held.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    busy       = (state_q != IDLE);
    if (state_q == IDLE && reset_n) begin
      req_ready = arb_grant;
    end
    if (state_q == RESP) begin
      resp_valid[gnt_q] = 1'b1;
    end
  end

  // Operands stay at the last issued op between accepts; no return to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q        <= '0;
      last_grant_q <= GNT_W'(N_REQ - 1);
      alu_opcode   <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      resp_data    <= '0;
    end else begin
      if (accept) begin
        gnt_q      <= arb_idx;
        alu_opcode <= sel_opcode;
        alu_a      <= sel_a;
        alu_b      <= sel_b;
      end
      if (state_q == CAPTURE) begin
        resp_data <= alu_c;
      end
      if (resp_done) begin
        last_grant_q <= gnt_q;
      end
    end
  end

endmodule
